sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the receive end of the team's PISO serial link.
- Collects WIDTH framed serial bits into a word and presents the word on a valid/ready parallel output.
- Contains a one-word holding buffer and overrun detection.
- Sits between the serial line (driven by a PISO transmitter) and downstream parallel logic.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in p_data[WIDTH-1]; 0 = first bit lands in p_data[0].

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in is valid this cycle (bit strobe).
- s_sync  input  1  qualifies s_in as bit 0 of a new word; only sampled when s_valid=1.
- p_data  output  WIDTH  received word; stable while p_valid=1.
- p_valid  output  1  p_data holds an unconsumed word.
- p_ready  input  1  downstream accepts p_data this cycle.
- busy  output  1  a word is partially received (state SHIFT).
- frame_err  output  1  one-cycle pulse: s_sync arrived mid-word.
- overrun  output  1  sticky flag: a completed word was dropped.
- clr_err  input  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, reset_n=0). State=IDLE; shift register, bit counter and p_data = 0; p_valid, busy, frame_err, overrun = 0. Reset mid-word or with p_valid=1 discards everything.
- Bit accept. A bit is consumed only on a clock edge where s_valid=1.
- Shift rule, MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], s_in}.
- Shift rule, MSB_FIRST=0: sreg <= {s_in, sreg[WIDTH-1:1]}.
- Bit counter: width $clog2(WIDTH). Counts bits accepted in the current word (0..WIDTH-1). No wrap beyond WIDTH-1.
- FSM state IDLE:
  - s_valid=1 & s_sync=1: load bit 0, cnt<=1, go to SHIFT.
  - s_valid=1 & s_sync=0: bit ignored, no error.
- FSM state SHIFT:
  - s_valid=1 & s_sync=0: shift, cnt++.
  - On the bit where cnt==WIDTH-1, the word is complete: go to IDLE, cnt<=0.
  - s_valid=1 & s_sync=1: partial word discarded; this bit becomes bit 0 (cnt<=1, stay in SHIFT); frame_err pulses for one cycle.
- busy = (state==SHIFT).
- Word completion:
  - The completed word is the shift expression including the final s_in.
  - If p_valid=0, or p_valid=1 & p_ready=1 in the same cycle: p_data<=word and p_valid<=1 on that edge.
  - Latency: p_valid is seen high in the cycle after the edge that sampled the last bit.
  - Otherwise the word is dropped, p_data is unchanged and overrun<=1.
- Output handshake: p_valid=1 & p_ready=1 with no completion that cycle gives p_valid<=0. p_data holds its value while p_valid=1.
- overrun:
  - Sticky until clr_err=1.
  - clr_err and a new overrun event in the same cycle: overrun stays 1 (set wins).
- WIDTH=2 corner: words complete on every second accepted bit; the rules above still apply.
- There is no combinational path from s_* to p_*; all outputs are registered.

Decomposition:
- Shared package (piso/sipo link pkg):
  - FSM state typedef {IDLE, SHIFT}.
  - Default WIDTH constant, shared with the PISO transmitter so both ends agree on word size.
  - MSB_FIRST default constant.
- Optional sub-module sipo_out_buf: one-entry valid/ready holding register plus overrun logic.
- The core shift/FSM stays in the top module.

Test Plan:
- Reset mid-word: WIDTH=4, two bits in, then reset_n=0. Expect busy=0, p_valid=0, p_data=0 immediately (asynchronous). After release, the next framed word is received correctly.
- Basic receive: MSB_FIRST=1, bits 1,0,1,1 with s_sync on the first bit, p_ready=1. Expect p_data=4'b1011 and p_valid=1 one cycle after the last bit. p_valid drops the following cycle.
- LSB-first receive: MSB_FIRST=0, bits 1,0,1,1. Expect p_data=4'b1101.
- Gapped bits and idle noise: s_valid toggling with gaps, and s_in bits before s_sync in IDLE. Expect IDLE bits ignored, word 4'b0110 assembled across gaps, frame_err never asserted.
- Mid-word resync: sync+1,0, then sync+0,1,1,1. Expect frame_err pulse on the second sync and p_data=4'b0111; the first partial word never appears.
- Overrun and back-to-back: p_ready=0, send 4'hA then 4'h5. Expect p_data stays 4'hA, overrun=1. Then p_ready=1 on the exact completion edge of word 4'h3: expect a seamless replace, p_data=4'h3, p_valid stays 1. clr_err clears overrun.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the PISO/SIPO serial link.
// Both ends import this package, so they always agree on word size and bit order.
package sipo_deserializer_pkg;

    // Receiver framing state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Word size used by both the transmitter and the receiver.
    localparam int LINK_WIDTH = 4;

    // 1: the first bit on the line is the word MSB. 0: the first bit is the LSB.
    localparam bit LINK_MSB_FIRST = 1'b1;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_deserializer_out_buf.sv
// One-entry valid/ready holding register for completed words.
// Also owns the sticky overrun flag.
// A completed word is dropped when the buffer is full and is not being drained that cycle.
module sipo_deserializer_out_buf
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH = LINK_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_word_valid,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_ready,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_room;

    // The buffer can take a new word if it is empty or is being drained this cycle.
    assign w_room = !r_valid || i_ready;

    // Load, drain, or hold the buffered word.
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_word_valid && w_room) begin
            r_data  <= i_word;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Overrun is sticky. A new drop in the same cycle as clr_err wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (i_word_valid && !w_room) begin
            r_overrun <= 1'b1;
        end else if (i_clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule : sipo_deserializer_out_buf

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver for the PISO link.
// It frames WIDTH bits, starting on s_sync, into a word.
// The word goes to a one-entry valid/ready output buffer.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int WIDTH     = LINK_WIDTH,
    parameter bit MSB_FIRST = LINK_MSB_FIRST
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_sync,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_frame_err;
    logic             w_frame_err_next;
    logic             w_word_done;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_loaded;

    // The shift register with the current bit appended, and a fresh word holding only this bit.
    assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], s_in} : {s_in, r_sreg[WIDTH-1:1]};
    assign w_loaded  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, s_in} : {s_in, {(WIDTH-1){1'b0}}};

    // Register the framing state, the shift register, the bit count and the frame-error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sreg      <= w_sreg_next;
            r_cnt       <= w_cnt_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Next-state logic: frame on s_sync, count accepted bits, detect completion and resync.
    // NOTE: each output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next     = r_state;
        w_sreg_next      = r_sreg;
        w_cnt_next       = r_cnt;
        w_frame_err_next = 1'b0;
        w_word_done      = 1'b0;

        if (s_valid) begin
            case (r_state)
                IDLE: begin
                    if (s_sync) begin
                        w_sreg_next  = w_loaded;
                        w_cnt_next   = CNT_ONE;
                        w_state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (s_sync) begin
                        // A sync arriving mid-word restarts framing on this bit.
                        w_sreg_next      = w_loaded;
                        w_cnt_next       = CNT_ONE;
                        w_frame_err_next = 1'b1;
                    end else begin
                        w_sreg_next = w_shifted;
                        if (r_cnt == CNT_LAST) begin
                            w_word_done  = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = IDLE;
                        end else begin
                            w_cnt_next = r_cnt + CNT_ONE;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    sipo_deserializer_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_word_valid (w_word_done),
        .i_word       (w_shifted),
        .i_ready      (p_ready),
        .i_clr_err    (clr_err),
        .o_data       (p_data),
        .o_valid      (p_valid),
        .o_overrun    (overrun)
    );

    assign busy      = (r_state == SHIFT);
    assign frame_err = r_frame_err;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer.
// It runs an MSB-first and an LSB-first instance side by side.
// Expected words come from a bit-list reference model and go into per-instance queues.
// A monitor pops a queue entry on every output transfer.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_in, s_valid, s_sync, p_ready, clr_err;
    logic [W-1:0] pd_m, pd_l;
    logic         pv_m, pv_l, busy_m, busy_l, fe_m, fe_l, ov_m, ov_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [W-1:0] exp_q_m[$];
    logic [W-1:0] exp_q_l[$];
    bit           m_bits[$];
    bit           m_in_word, m_pv, m_ovr, m_fe;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .p_data(pd_m), .p_valid(pv_m), .p_ready(p_ready), .busy(busy_m),
        .frame_err(fe_m), .overrun(ov_m), .clr_err(clr_err)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .p_data(pd_l), .p_valid(pv_l), .p_ready(p_ready), .busy(busy_l),
        .frame_err(fe_l), .overrun(ov_l), .clr_err(clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, built from the framing rules on a list of received bits.
    task automatic model_edge(input bit sv, input bit sy, input bit si, input bit rdy, input bit clr);
        bit           done = 1'b0;
        bit           ovr_evt = 1'b0;
        logic [W-1:0] wm = '0;
        logic [W-1:0] wl = '0;
        m_fe = 1'b0;
        if (sv) begin
            if (sy) begin
                m_fe = m_in_word;
                m_bits.delete();
                m_bits.push_back(si);
                m_in_word = 1'b1;
            end else if (m_in_word) begin
                m_bits.push_back(si);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = m_bits[i];
                        wl[i]     = m_bits[i];
                    end
                    done = 1'b1;
                    m_in_word = 1'b0;
                    m_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_pv || rdy) begin
                exp_q_m.push_back(wm);
                exp_q_l.push_back(wl);
                m_pv = 1'b1;
            end else begin
                ovr_evt = 1'b1;
            end
        end else if (m_pv && rdy) begin
            m_pv = 1'b0;
        end
        if (ovr_evt) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic model_reset();
        m_bits.delete();
        exp_q_m.delete();
        exp_q_l.delete();
        m_in_word = 1'b0;
        m_pv = 1'b0;
        m_ovr = 1'b0;
        m_fe = 1'b0;
    endtask

    // Called just after a rising edge. Drives one cycle of inputs, then checks the flags against the model.
    task automatic step(input bit sv, input bit sy, input bit si, input bit rdy, input bit clr);
        s_valid = sv; s_sync = sy; s_in = si; p_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_edge(sv, sy, si, rdy, clr);
        #1;
        check("m_busy", 32'(busy_m), 32'(m_in_word));
        check("l_busy", 32'(busy_l), 32'(m_in_word));
        check("m_frame_err", 32'(fe_m), 32'(m_fe));
        check("l_frame_err", 32'(fe_l), 32'(m_fe));
        check("m_p_valid", 32'(pv_m), 32'(m_pv));
        check("l_p_valid", 32'(pv_l), 32'(m_pv));
        check("m_overrun", 32'(ov_m), 32'(m_ovr));
        check("l_overrun", 32'(ov_l), 32'(m_ovr));
    endtask

    // Sends one framed word, given in line order: b[W-1] goes on the line first.
    task automatic send_word(input logic [W-1:0] b, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(1'b1, i == W - 1, b[i], rdy, 1'b0);
    endtask

    // Monitor: every transfer (p_valid and p_ready before an edge) consumes one expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && pv_m && p_ready) begin
                if (exp_q_m.size() == 0) check("m_spurious_word", 32'(pv_m), 32'd0);
                else check("m_word", 32'(pd_m), 32'(exp_q_m.pop_front()));
            end
            if (reset_n && pv_l && p_ready) begin
                if (exp_q_l.size() == 0) check("l_spurious_word", 32'(pv_l), 32'd0);
                else check("l_word", 32'(pd_l), 32'(exp_q_l.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        s_in = 1'b0; s_valid = 1'b0; s_sync = 1'b0; p_ready = 1'b0; clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_p_valid", 32'(pv_m | pv_l), 32'd0);
        check("reset_busy", 32'(busy_m | busy_l), 32'd0);
        check("reset_p_data", 32'({pd_m, pd_l}), 32'd0);
        check("reset_flags", 32'({fe_m, fe_l, ov_m, ov_l}), 32'd0);
        reset_n = 1'b1;

        // Reset mid-word is asynchronous and discards the partial word.
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        reset_n = 1'b0;
        #1;
        check("midword_reset_busy", 32'(busy_m | busy_l), 32'd0);
        check("midword_reset_p_valid", 32'(pv_m | pv_l), 32'd0);
        check("midword_reset_p_data", 32'({pd_m, pd_l}), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_word(4'b1001, 1);
        check("after_reset_word_m", 32'(pd_m), 32'h9);

        // Basic receive: the word is visible in the cycle after its last bit.
        send_word(4'b1011, 1);
        check("basic_m_1011", 32'(pd_m), 32'hB);
        check("basic_l_1101", 32'(pd_l), 32'hD);
        step(0, 0, 0, 1, 0);

        // Gapped bits, with idle noise before the sync.
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        check("gapped_m_0110", 32'(pd_m), 32'h6);
        check("gapped_l_0110", 32'(pd_l), 32'h6);

        // Mid-word resync: the first partial word never appears.
        step(1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check("resync_frame_err_m", 32'(fe_m), 32'd1);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        check("resync_m_0111", 32'(pd_m), 32'h7);
        check("resync_l_1110", 32'(pd_l), 32'hE);

        // Overrun, then a seamless replace on the completion edge, then clear.
        step(0, 0, 0, 1, 0);
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        check("overrun_hold_m_A", 32'(pd_m), 32'hA);
        check("overrun_set_m", 32'(ov_m), 32'd1);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 0);
        check("replace_m_3", 32'(pd_m), 32'h3);
        check("replace_valid_m", 32'(pv_m), 32'd1);
        step(0, 0, 0, 0, 1);
        check("clr_err_m", 32'(ov_m), 32'd0);
        step(0, 0, 0, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        // Drain whatever is still buffered. Every expected word must have been seen.
        repeat (3) step(0, 0, 0, 1, 0);
        check("scoreboard_empty_m", 32'(exp_q_m.size()), 32'd0);
        check("scoreboard_empty_l", 32'(exp_q_l.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sipo_deserializer
